// File: rtl/ksa_pkg.sv
// ksa_pkg -- shared definitions for the KSA shuffler.
//
// Contents:
//   STATE_W     : width of the stateTap debug encoding
//   SWAP_CYCLES : clock cycles spent on each index i of the shuffle
//   ksa_state_t : FSM state enum; the numeric values are the stateTap encoding
package ksa_pkg;

    localparam int STATE_W     = 4;
    localparam int SWAP_CYCLES = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_INIT    = 4'd1,
        ST_READ_I  = 4'd2,
        ST_WAIT_I  = 4'd3,
        ST_READ_J  = 4'd4,
        ST_WAIT_J  = 4'd5,
        ST_WRITE_I = 4'd6,
        ST_WRITE_J = 4'd7,
        ST_DONE    = 4'd8
    } ksa_state_t;

endpackage

// File: rtl/ksa_key_index.sv
// ksa_key_index -- latched key storage, wrapping key-byte counter and byte mux.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : latch key/key_len and restart the counter at byte 0
//   advance    : step to the next key byte, wrapping after the last active byte
//   key        : key bytes, byte 0 in the most significant slice
//   key_len    : active length; 0 or above KEY_MAX_LEN means KEY_MAX_LEN
//   key_byte   : current key byte, zero-extended/truncated to IDX_W bits
module ksa_key_index #(
    parameter int KEY_MAX_LEN = 3,
    parameter int RAM_WIDTH   = 8,
    parameter int IDX_W       = 8,
    parameter int LEN_W       = $clog2(KEY_MAX_LEN + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  load,
    input  logic                                  advance,
    input  logic [KEY_MAX_LEN-1:0][RAM_WIDTH-1:0] key,
    input  logic [LEN_W-1:0]                      key_len,
    output logic [IDX_W-1:0]                      key_byte
);

    import ksa_pkg::*;

    // At least one bit even when only a single key byte exists.
    localparam int KW = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1;

    logic [KEY_MAX_LEN-1:0][RAM_WIDTH-1:0] key_q;
    logic [KW-1:0]                         last_q;
    logic [KW-1:0]                         idx_q;
    logic [KW-1:0]                         eff_last;
    logic [RAM_WIDTH-1:0]                  sel;

    // Last active byte index; out-of-range lengths fall back to the full key.
    always_comb begin
        eff_last = KW'(KEY_MAX_LEN - 1);
        if (key_len != '0 && int'(key_len) <= KEY_MAX_LEN) begin
            eff_last = KW'(int'(key_len) - 1);
        end
    end

    // The counter replaces i mod key_len: it steps once per shuffle index.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q  <= '0;
            last_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            key_q  <= key;
            last_q <= eff_last;
            idx_q  <= '0;
        end else if (advance) begin
            idx_q <= (idx_q == last_q) ? '0 : idx_q + KW'(1);
        end
    end

    // Byte 0 lives in the top slice, so byte b is slice KEY_MAX_LEN-1-b.
    always_comb begin
        sel = '0;
        for (int b = 0; b < KEY_MAX_LEN; b++) begin
            if (idx_q == KW'(b)) begin
                sel = key_q[KEY_MAX_LEN-1-b];
            end
        end
        key_byte = IDX_W'(sel);
    end

endmodule

// File: rtl/ksa_shuffler_gen.sv
// ksa_shuffler_gen -- RC4 key-scheduling (KSA) shuffle engine driving an
// external synchronous RAM holding the S-box.
//
// Build option: define KSA_SHUFFLER_INIT_EN to include the INIT phase that
// writes S[i]=i before shuffling; without it the RAM must be preloaded.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset (wins over start)
//   start         : level request, sampled only in IDLE; key/key_len are
//                   latched on the IDLE->run edge. The engine acknowledges by
//                   raising finished, held until start is seen low.
//   key, key_len  : key bytes (byte 0 most significant slice), active length
//   ram_out       : RAM read data, valid the cycle after address is presented
//   address       : RAM address
//   ram_in        : RAM write data
//   write_enable  : RAM write strobe
//   finished      : high in DONE
//   iTap, jTap    : live i and j indices
//   stateTap      : FSM state encoding (ksa_state_t values)
module ksa_shuffler_gen #(
    parameter int RAM_LENGTH  = 256,
    parameter int RAM_WIDTH   = 8,
    parameter int KEY_MAX_LEN = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [KEY_MAX_LEN-1:0][RAM_WIDTH-1:0] key,
    input  logic [$clog2(KEY_MAX_LEN+1)-1:0]      key_len,
    input  logic [RAM_WIDTH-1:0]                  ram_out,
    output logic [$clog2(RAM_LENGTH)-1:0]         address,
    output logic [RAM_WIDTH-1:0]                  ram_in,
    output logic                                  write_enable,
    output logic                                  finished,
    output logic [$clog2(RAM_LENGTH)-1:0]         iTap,
    output logic [$clog2(RAM_LENGTH)-1:0]         jTap,
    output logic [3:0]                            stateTap
);

    import ksa_pkg::*;

    localparam int AW = $clog2(RAM_LENGTH);
    localparam logic [AW-1:0] I_LAST = AW'(RAM_LENGTH - 1);

    ksa_state_t           state_q, state_d;
    logic [AW-1:0]        i_q, i_d;
    logic [AW-1:0]        j_q, j_d;
    logic [RAM_WIDTH-1:0] si_q, si_d;
    logic [RAM_WIDTH-1:0] sj_q, sj_d;
    logic [AW-1:0]        key_byte;
    logic [AW-1:0]        j_sum;
    logic                 key_load;
    logic                 key_adv;

    ksa_key_index #(
        .KEY_MAX_LEN (KEY_MAX_LEN),
        .RAM_WIDTH   (RAM_WIDTH),
        .IDX_W       (AW)
    ) u_key_index (
        .clk      (clk),
        .reset    (reset),
        .load     (key_load),
        .advance  (key_adv),
        .key      (key),
        .key_len  (key_len),
        .key_byte (key_byte)
    );

    // Index arithmetic wraps naturally at AW bits (RAM_LENGTH is a power of two).
    assign j_sum = j_q + AW'(si_q) + key_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        si_d         = si_q;
        sj_d         = sj_q;
        address      = '0;
        ram_in       = '0;
        write_enable = 1'b0;
        finished     = 1'b0;
        key_load     = 1'b0;
        key_adv      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_load = 1'b1;
                    i_d      = '0;
                    j_d      = '0;
`ifdef KSA_SHUFFLER_INIT_EN
                    state_d  = ST_INIT;
`else
                    state_d  = ST_READ_I;
`endif
                end
            end
`ifdef KSA_SHUFFLER_INIT_EN
            ST_INIT: begin
                address      = i_q;
                ram_in       = RAM_WIDTH'(i_q);
                write_enable = 1'b1;
                if (i_q == I_LAST) begin
                    i_d     = '0;
                    state_d = ST_READ_I;
                end else begin
                    i_d = i_q + AW'(1);
                end
            end
`endif
            ST_READ_I: begin
                address = i_q;
                state_d = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                si_d    = ram_out;
                state_d = ST_READ_J;
            end
            ST_READ_J: begin
                // Read S[j_next] straight away; j takes the new value on this edge.
                address = j_sum;
                j_d     = j_sum;
                state_d = ST_WAIT_J;
            end
            ST_WAIT_J: begin
                sj_d    = ram_out;
                state_d = ST_WRITE_I;
            end
            ST_WRITE_I: begin
                address      = i_q;
                ram_in       = sj_q;
                write_enable = 1'b1;
                state_d      = ST_WRITE_J;
            end
            ST_WRITE_J: begin
                // Written second, so when i==j the entry ends up holding si.
                address      = j_q;
                ram_in       = si_q;
                write_enable = 1'b1;
                key_adv      = 1'b1;
                if (i_q == I_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + AW'(1);
                    state_d = ST_READ_I;
                end
            end
            ST_DONE: begin
                finished = 1'b1;
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign iTap     = i_q;
    assign jTap     = j_q;
    assign stateTap = state_q;

endmodule

// File: tb/tb_ksa_shuffler_gen.sv
// tb_ksa_shuffler_gen -- self-checking bench for ksa_shuffler_gen.
// Instance A: RAM_LENGTH=8, KEY_MAX_LEN=3. Instance B: RAM_LENGTH=4, KEY_MAX_LEN=1.
// Both builds (KSA_SHUFFLER_INIT_EN defined or not) are handled.
module tb_ksa_shuffler_gen;

    import ksa_pkg::*;

`ifdef KSA_SHUFFLER_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif
    // Start sampled at edge 0 counts as cycle 1; optional 8 INIT cycles,
    // 8 indices of SWAP_CYCLES each, then DONE.
    localparam int EXP_LAT = 1 + 8 * SWAP_CYCLES + (INIT_EN ? 8 : 0);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic             reset_a, start_a;
    logic [2:0][7:0]  key_a;
    logic [1:0]       key_len_a;
    logic [7:0]       ram_out_a, rd_a, ram_in_a;
    logic [2:0]       address_a, itap_a, jtap_a;
    logic             we_a, fin_a;
    logic [3:0]       state_a;

    ksa_shuffler_gen #(.RAM_LENGTH(8), .RAM_WIDTH(8), .KEY_MAX_LEN(3)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .key(key_a), .key_len(key_len_a),
        .ram_out(ram_out_a), .address(address_a), .ram_in(ram_in_a),
        .write_enable(we_a), .finished(fin_a), .iTap(itap_a), .jTap(jtap_a),
        .stateTap(state_a)
    );

    // ---------------- instance B ----------------
    logic             reset_b, start_b;
    logic [0:0][7:0]  key_b;
    logic [0:0]       key_len_b;
    logic [7:0]       ram_out_b, ram_in_b;
    logic [1:0]       address_b, itap_b, jtap_b;
    logic             we_b, fin_b;
    logic [3:0]       state_b;

    ksa_shuffler_gen #(.RAM_LENGTH(4), .RAM_WIDTH(8), .KEY_MAX_LEN(1)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .key(key_b), .key_len(key_len_b),
        .ram_out(ram_out_b), .address(address_b), .ram_in(ram_in_b),
        .write_enable(we_b), .finished(fin_b), .iTap(itap_b), .jTap(jtap_b),
        .stateTap(state_b)
    );

    // ---------------- RAM models ----------------
    logic [7:0]  mem_a [8];
    logic [7:0]  mem_b [4];
    logic        stuck;
    logic        pl_we_a, pl_we_b;
    logic [2:0]  pl_addr;
    logic [7:0]  pl_data;
    logic [10:0] wlog[$];

    always @(posedge clk) begin
        if (pl_we_a) mem_a[pl_addr] <= pl_data;
        else if (we_a) mem_a[address_a] <= ram_in_a;
        rd_a <= mem_a[address_a];
        if (we_a) wlog.push_back({address_a, ram_in_a});
    end
    assign ram_out_a = stuck ? 8'h40 : rd_a;

    always @(posedge clk) begin
        if (pl_we_b) mem_b[pl_addr[1:0]] <= pl_data;
        else if (we_b) mem_b[address_b] <= ram_in_b;
        ram_out_b <= mem_b[address_b];
    end

    // write_enable must only be seen in INIT, WRITE_I, WRITE_J.
    int we_viol = 0;
    always @(negedge clk) begin
        if (we_a === 1'b1 && !(state_a inside {4'd1, 4'd6, 4'd7})) we_viol++;
    end

    // ---------------- scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [10:0] exp_q[$];
    int          exp_mem [8];
    int          pre_s [8];
    int          run_key [3];
    int          run_len;
    logic [7:0]  pre_v [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: textbook KSA over an 8-entry array, all arithmetic mod 8.
    task automatic build_model(input bit stk);
        int s [8];
        int j, si, sj, len;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (INIT_EN) begin
                s[i] = i;
                exp_q.push_back({3'(i), 8'(i)});
            end else begin
                s[i] = pre_s[i];
            end
        end
        len = (run_len == 0 || run_len > 3) ? 3 : run_len;
        j = 0;
        for (int i = 0; i < 8; i++) begin
            si = stk ? 64 : s[i];
            j  = (j + si + run_key[i % len]) % 8;
            sj = stk ? 64 : s[j];
            s[i] = sj;
            exp_q.push_back({3'(i), 8'(sj)});
            s[j] = si;
            exp_q.push_back({3'(j), 8'(si)});
        end
        for (int i = 0; i < 8; i++) exp_mem[i] = s[i];
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload_a();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pl_we_a = 1'b1;
            pl_addr = 3'(i);
            pl_data = pre_v[i];
        end
        @(negedge clk);
        pl_we_a = 1'b0;
    endtask

    task automatic random_preload();
        for (int i = 0; i < 8; i++) pre_v[i] = 8'($urandom);
        preload_a();
    endtask

    task automatic do_run(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2,
                          input logic [1:0] len, input int drop_after, input bit stk);
        int cyc, base;
        bit got;
        for (int i = 0; i < 8; i++) pre_s[i] = int'(mem_a[i]);
        run_key[0] = int'(k0);
        run_key[1] = int'(k1);
        run_key[2] = int'(k2);
        run_len = int'(len);
        build_model(stk);
        base = wlog.size();
        @(negedge clk);
        stuck     = stk;
        key_a     = {k0, k1, k2};
        key_len_a = len;
        start_a   = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            // Inputs changing after the latch must have no effect.
            key_a     = {8'($urandom), 8'($urandom), 8'($urandom)};
            key_len_a = 2'($urandom);
            if (drop_after > 0 && cyc == drop_after) start_a = 1'b0;
            if (fin_a === 1'b1) got = 1'b1;
        end
        check("latency", 32'(cyc), 32'(EXP_LAT));
        if (start_a) begin
            repeat (3) begin
                @(negedge clk);
                check("finished_hold", 32'(fin_a), 32'd1);
            end
            start_a = 1'b0;
        end
        @(negedge clk);
        check("finished_drop", 32'(fin_a), 32'd0);
        check("idle_after_done", 32'(state_a), 32'd0);
        stuck = 1'b0;
        check("write_count", 32'(wlog.size() - base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (base + k < wlog.size()) check("write_pair", 32'(wlog[base + k]), 32'(exp_q[k]));
        end
        if (!stk) begin
            for (int i = 0; i < 8; i++) check("final_ram", 32'(mem_a[i]), 32'(exp_mem[i]));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int cyc;
        bit found;
        logic [7:0] res0 [8];
        logic [7:0] k0, k1, k2;
        reset_a = 1'b1; start_a = 1'b0; key_a = '0; key_len_a = '0;
        reset_b = 1'b1; start_b = 1'b0; key_b = '0; key_len_b = '0;
        stuck = 1'b0; pl_we_a = 1'b0; pl_we_b = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_we", 32'(we_a), 32'd0);
        check("rst_finished", 32'(fin_a), 32'd0);
        check("rst_i", 32'(itap_a), 32'd0);
        check("rst_j", 32'(jtap_a), 32'd0);
        check("rst_address", 32'(address_a), 32'd0);
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Random keys and preloads; key_len sweeps 0..3; one run drops start early.
        for (int r = 0; r < 4; r++) begin
            random_preload();
            do_run(8'($urandom), 8'($urandom), 8'($urandom), 2'(r), (r == 2) ? 10 : 0, 1'b0);
        end

        // key_len=0 must behave exactly like key_len=3.
        k0 = 8'($urandom); k1 = 8'($urandom); k2 = 8'($urandom);
        random_preload();
        do_run(k0, k1, k2, 2'd0, 0, 1'b0);
        for (int i = 0; i < 8; i++) res0[i] = mem_a[i];
        preload_a();
        do_run(k0, k1, k2, 2'd3, 0, 1'b0);
        for (int i = 0; i < 8; i++) check("len0_equals_len3", 32'(mem_a[i]), 32'(res0[i]));

        // Reset during WAIT_J of i=3, start held high so reset must win.
        random_preload();
        @(negedge clk);
        key_a = {8'($urandom), 8'($urandom), 8'($urandom)};
        key_len_a = 2'd3;
        start_a = 1'b1;
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (state_a == 4'd5 && itap_a == 3'd3) found = 1'b1;
        end
        check("reach_wait_j_i3", 32'(found), 32'd1);
        reset_a = 1'b1;
        @(negedge clk);
        check("midrst_state", 32'(state_a), 32'd0);
        check("midrst_we", 32'(we_a), 32'd0);
        check("midrst_finished", 32'(fin_a), 32'd0);
        check("midrst_i", 32'(itap_a), 32'd0);
        check("midrst_j", 32'(jtap_a), 32'd0);
        reset_a = 1'b0;
        start_a = 1'b0;
        do_run(8'($urandom), 8'($urandom), 8'($urandom), 2'd3, 0, 1'b0);

        // ram_out stuck at 0x40, key byte 0 = 1, key_len = 1: j steps 1..7,0.
        do_run(8'h01, 8'($urandom), 8'($urandom), 2'd1, 0, 1'b1);

        // Instance B: 4 entries, key 0x00, from identity -> [0,2,3,1].
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pl_we_b = 1'b1;
            pl_addr = 3'(i);
            pl_data = INIT_EN ? 8'(8'hA0 + i) : 8'(i);
        end
        @(negedge clk);
        pl_we_b = 1'b0;
        key_b = '0;
        key_len_b = 1'b1;
        start_b = 1'b1;
        cyc = 0;
        while (fin_b !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("b_finished", 32'(fin_b), 32'd1);
        check("b_ram0", 32'(mem_b[0]), 32'd0);
        check("b_ram1", 32'(mem_b[1]), 32'd2);
        check("b_ram2", 32'(mem_b[2]), 32'd3);
        check("b_ram3", 32'(mem_b[3]), 32'd1);
        start_b = 1'b0;
        @(negedge clk);

        check("we_outside_write_states", 32'(we_viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
